// File: rtl/dmem_bus_adapter_pkg.sv
// ============================================================================
// Module   : dmem_bus_adapter_pkg
// Brief    : Shared funct3 size codes and FSM encoding for the DMem bus adapter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_bus_adapter_pkg;

    localparam logic [2:0] c_MEM_B  = 3'b000;
    localparam logic [2:0] c_MEM_H  = 3'b001;
    localparam logic [2:0] c_MEM_W  = 3'b010;
    localparam logic [2:0] c_MEM_BU = 3'b100;
    localparam logic [2:0] c_MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_bus_adapter_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Byte-lane strobe/replication, load extraction and legality check
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import dmem_bus_adapter_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] read_word_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        illegal_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = read_word_i[{offset_i, 3'b000} +: 8];
    assign w_half = offset_i[1] ? read_word_i[31:16] : read_word_i[15:0];

    always_comb begin
        wstrb_o     = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = read_word_i;
        illegal_o   = 1'b0;
        case (funct3_i)
            c_MEM_B: begin
                wstrb_o     = 4'b0001 << offset_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{w_byte[7]}}, w_byte};
            end
            c_MEM_H: begin
                illegal_o   = offset_i[0];
                wstrb_o     = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{w_half[15]}}, w_half};
            end
            c_MEM_W: begin
                illegal_o   = |offset_i;
                wstrb_o     = 4'b1111;
            end
            c_MEM_BU: begin
                illegal_o   = is_store_i;
                load_data_o = {24'd0, w_byte};
            end
            c_MEM_HU: begin
                illegal_o   = is_store_i | offset_i[0];
                load_data_o = {16'd0, w_half};
            end
            default: illegal_o = 1'b1;
        endcase
        // Loads never assert byte strobes on the bus.
        if (!is_store_i) begin
            wstrb_o = 4'b0000;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bus_adapter.sv
// ============================================================================
// Module   : dmem_bus_adapter
// Brief    : MEM-stage load/store to valid/ready word bus adapter with stall
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_adapter
    import dmem_bus_adapter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_funct3,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_misalign,
    output logic              bus_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [3:0]        bus_req_wstrb,
    output logic [31:0]       bus_req_wdata,
    input  logic              bus_resp_valid,
    input  logic [31:0]       bus_resp_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] c_TO_LIMIT = TIMEOUT[CNT_W:0];

    state_e            state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              w_idle;
    logic [2:0]        w_funct3;
    logic [1:0]        w_offset;
    logic              w_is_store;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load;
    logic              w_illegal;
    logic              w_req;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_timeout;

    // The aligner sees the live request in IDLE and the latched one afterwards.
    assign w_idle     = (state_q == ST_IDLE);
    assign w_funct3   = w_idle ? cpu_funct3 : funct3_q;
    assign w_offset   = w_idle ? cpu_addr[1:0] : offset_q;
    assign w_is_store = w_idle ? cpu_we : bus_req_we;
    assign w_req      = cpu_re | cpu_we;

    mem_lane_align u_align (
        .funct3_i     (w_funct3),
        .is_store_i   (w_is_store),
        .offset_i     (w_offset),
        .store_data_i (cpu_wdata),
        .read_word_i  (bus_resp_rdata),
        .wstrb_o      (w_wstrb),
        .wdata_o      (w_wdata),
        .load_data_o  (w_load),
        .illegal_o    (w_illegal)
    );

    assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == c_TO_LIMIT);

    // Gated by reset so an abandoned transaction releases the pipeline at once.
    assign cpu_stall = rst & ((w_idle & w_req & ~w_illegal) |
                              (state_q == ST_REQ) | (state_q == ST_RESP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            cnt_q         <= '0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wstrb <= 4'b0000;
            bus_req_wdata <= 32'd0;
            cpu_rdata     <= 32'd0;
            cpu_misalign  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            cpu_misalign <= 1'b0;
            bus_err      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            cpu_misalign <= 1'b1;
                        end else begin
                            bus_req_valid <= 1'b1;
                            bus_req_we    <= cpu_we;
                            bus_req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                            bus_req_wstrb <= w_wstrb;
                            bus_req_wdata <= w_wdata;
                            funct3_q      <= cpu_funct3;
                            offset_q      <= cpu_addr[1:0];
                            state_q       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= bus_req_we ? ST_DONE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus_resp_valid) begin
                        cpu_rdata <= w_load;
                        state_q   <= ST_DONE;
                    end else if (w_timeout) begin
                        cpu_rdata <= 32'd0;
                        bus_err   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_adapter.sv
// ============================================================================
// Module   : tb_dmem_bus_adapter
// Brief    : Directed table-driven bench for dmem_bus_adapter (TIMEOUT = 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_bus_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [2:0]  cpu_funct3 = 3'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_misalign;
    logic        bus_err;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_rdata = 32'd0;

    dmem_bus_adapter #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_funct3     (cpu_funct3),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .cpu_misalign   (cpu_misalign),
        .bus_err        (bus_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_we     (bus_req_we),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_req_wdata  (bus_req_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        int          rdly;
        int          respdly;
        logic [31:0] word;
        logic        ill;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] erdata;
        logic        err;
        int          estall;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_rdata = 32'd0;
    vec_t        vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 32'd0;
        cpu_funct3 = 3'd0;
        cpu_wdata = 32'd0;
    endtask

    task automatic run_access(input vec_t v, input int idx);
        int          stall_cyc;
        int          wcnt;
        int          rwait;
        int          nhs;
        bit          in_resp;
        bit          saw_valid;
        bit          done;
        bit          stable;
        bit          hs_now;
        bit          resp_now;
        logic [31:0] c_addr;
        logic [3:0]  c_strb;
        logic [31:0] c_wdata;
        logic        c_we;
        stall_cyc = 0; wcnt = 0; rwait = 0; nhs = 0;
        in_resp = 0; saw_valid = 0; done = 0; stable = 1;
        c_addr = 32'd0; c_strb = 4'd0; c_wdata = 32'd0; c_we = 1'b0;

        @(negedge clk);
        cpu_re = v.re; cpu_we = v.we; cpu_addr = v.addr;
        cpu_funct3 = v.f3; cpu_wdata = v.wdata;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1;
        if (v.ill) begin
            chk($sformatf("v%0d_ill_stall", idx), {31'd0, cpu_stall}, 32'd0);
            @(negedge clk);
            clear_inputs();
            #1;
            chk($sformatf("v%0d_misalign", idx), {31'd0, cpu_misalign}, 32'd1);
            chk($sformatf("v%0d_ill_novalid", idx), {31'd0, bus_req_valid}, 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_misalign_end", idx), {31'd0, cpu_misalign}, 32'd0);
            chk($sformatf("v%0d_ill_rdata", idx), cpu_rdata, last_rdata);
            return;
        end

        for (int c = 0; c < 64; c++) begin
            if (saw_valid && !cpu_stall) begin
                done = 1;
                break;
            end
            if (cpu_stall) stall_cyc++;
            if (bus_req_valid) begin
                if (!saw_valid) begin
                    c_addr = bus_req_addr; c_strb = bus_req_wstrb;
                    c_wdata = bus_req_wdata; c_we = bus_req_we;
                end else if (bus_req_addr !== c_addr || bus_req_wstrb !== c_strb ||
                             bus_req_wdata !== c_wdata || bus_req_we !== c_we) begin
                    stable = 0;
                end
                saw_valid = 1;
                bus_req_ready = (wcnt >= v.rdly);
                wcnt++;
            end else begin
                bus_req_ready = 1'b0;
            end
            if (in_resp) begin
                bus_resp_valid = (rwait >= v.respdly);
                rwait++;
            end else begin
                bus_resp_valid = 1'b0;
            end
            bus_resp_rdata = bus_resp_valid ? v.word : 32'hA5A5_5A5A;
            hs_now = bus_req_valid && bus_req_ready;
            resp_now = bus_resp_valid;
            if (hs_now) nhs++;
            @(negedge clk);
            #1;
            if (hs_now && !v.we) in_resp = 1;
            if (resp_now) in_resp = 0;
        end
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;

        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_stall_cycles", idx), stall_cyc, v.estall);
        chk($sformatf("v%0d_handshakes", idx), nhs, 32'd1);
        chk($sformatf("v%0d_addr", idx), c_addr, v.eaddr);
        chk($sformatf("v%0d_wstrb", idx), {28'd0, c_strb}, {28'd0, v.estrb});
        chk($sformatf("v%0d_we", idx), {31'd0, c_we}, {31'd0, v.we});
        chk($sformatf("v%0d_stable", idx), {31'd0, stable}, 32'd1);
        chk($sformatf("v%0d_bus_err", idx), {31'd0, bus_err}, {31'd0, v.err});
        if (v.we) begin
            chk($sformatf("v%0d_wdata", idx), c_wdata, v.ewdata);
            chk($sformatf("v%0d_rdata_kept", idx), cpu_rdata, last_rdata);
        end else begin
            chk($sformatf("v%0d_rdata", idx), cpu_rdata, v.erdata);
            last_rdata = v.erdata;
        end

        @(negedge clk);
        clear_inputs();
        #1;
        chk($sformatf("v%0d_idle_after", idx),
            {29'd0, cpu_stall, bus_req_valid, bus_err}, 32'd0);
    endtask

    initial begin
        logic [6:0] exp_st;
        int         nhs;
        vec_t       v;

        vecs[0]  = '{1'b0, 1'b1, 32'h1003, 3'b000, 32'h123456AB, 0, 0, 32'h0, 1'b0,
                     32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 1'b0, 2};
        vecs[1]  = '{1'b1, 1'b0, 32'h2001, 3'b000, 32'h0, 3, 0, 32'h000080FF, 1'b0,
                     32'h2000, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 6};
        vecs[2]  = '{1'b1, 1'b0, 32'h2001, 3'b100, 32'h0, 3, 0, 32'h000080FF, 1'b0,
                     32'h2000, 4'b0000, 32'h0, 32'h00000080, 1'b0, 6};
        vecs[3]  = '{1'b1, 1'b0, 32'h0003, 3'b001, 32'h0, 0, 0, 32'h0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0002, 3'b010, 32'h11111111, 0, 0, 32'h0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000, 3'b011, 32'h0, 0, 0, 32'h0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0102, 3'b001, 32'h1234CAFE, 1, 0, 32'h0, 1'b0,
                     32'h0100, 4'b1100, 32'hCAFECAFE, 32'h0, 1'b0, 3};
        vecs[7]  = '{1'b0, 1'b1, 32'h0004, 3'b010, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0,
                     32'h0004, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 2};
        vecs[8]  = '{1'b1, 1'b0, 32'h0006, 3'b001, 32'h0, 0, 2, 32'h80017FFF, 1'b0,
                     32'h0004, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 5};
        vecs[9]  = '{1'b1, 1'b0, 32'h0008, 3'b010, 32'h0, 0, 99, 32'hFFFFFFFF, 1'b0,
                     32'h0008, 4'b0000, 32'h0, 32'h00000000, 1'b1, 6};
        vecs[10] = '{1'b1, 1'b0, 32'h0008, 3'b010, 32'h0, 0, 0, 32'h12345678, 1'b0,
                     32'h0008, 4'b0000, 32'h0, 32'h12345678, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b1, 32'h0000, 3'b101, 32'h5555, 0, 0, 32'h0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b1, 32'h0000, 3'b000, 32'h00000077, 0, 0, 32'h0, 1'b0,
                     32'h0000, 4'b0001, 32'h77777777, 32'h0, 1'b0, 2};
        vecs[13] = '{1'b1, 1'b0, 32'h0000, 3'b000, 32'h0, 0, 0, 32'h0000007F, 1'b0,
                     32'h0000, 4'b0000, 32'h0, 32'h0000007F, 1'b0, 3};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rst_we", {31'd0, bus_req_we}, 32'd0);
        chk("rst_addr", bus_req_addr, 32'd0);
        chk("rst_wstrb", {28'd0, bus_req_wstrb}, 32'd0);
        chk("rst_wdata", bus_req_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_flags", {30'd0, cpu_misalign, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_access(vecs[i], i);
        end

        // Back-to-back SW then LW with an always-ready, always-responding bus.
        exp_st = 7'b0111011;
        nhs = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            cpu_addr = 32'h0; cpu_funct3 = 3'b010; cpu_wdata = 32'hCAFEF00D;
            cpu_we = (c < 3); cpu_re = (c >= 3);
            bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h55AA1234;
            #1;
            chk($sformatf("b2b_stall_c%0d", c), {31'd0, cpu_stall}, {31'd0, exp_st[c]});
            if (bus_req_valid && bus_req_ready) nhs++;
        end
        chk("b2b_rdata", cpu_rdata, 32'h55AA1234);
        chk("b2b_transactions", nhs, 32'd2);
        @(negedge clk);
        clear_inputs();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        last_rdata = 32'h55AA1234;

        // Reset while a request is waiting in REQ.
        @(negedge clk);
        cpu_re = 1'b1; cpu_addr = 32'h10; cpu_funct3 = 3'b010;
        #1;
        chk("rstreq_stall_idle", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("rstreq_valid_before", {31'd0, bus_req_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstreq_valid_async", {31'd0, bus_req_valid}, 32'd0);
        chk("rstreq_stall_async", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("rstreq_after", {30'd0, cpu_stall, bus_req_valid}, 32'd0);

        // Reset while waiting for a read response.
        @(negedge clk);
        cpu_re = 1'b1; cpu_addr = 32'h0; cpu_funct3 = 3'b010;
        bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstresp_stall_resp", {31'd0, cpu_stall}, 32'd1);
        chk("rstresp_valid_resp", {31'd0, bus_req_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstresp_stall_async", {31'd0, cpu_stall}, 32'd0);
        chk("rstresp_rdata_async", cpu_rdata, 32'd0);
        @(negedge clk);
        clear_inputs();
        bus_req_ready = 1'b0;
        rst = 1'b1;
        last_rdata = 32'd0;

        v = '{1'b1, 1'b0, 32'h0002, 3'b101, 32'h0, 0, 0, 32'hBEEF0000, 1'b0,
              32'h0000, 4'b0000, 32'h0, 32'h0000BEEF, 1'b0, 3};
        run_access(v, 99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
